fetch_flow_controller: RTL
==========================

Name: fetch_flow_controller

Overview:
- Sequences instruction fetch into the instruction loop buffer.
- Issues in-order fetch requests to the instruction memory port and caps the number in flight.
- Throttles on the buffer's fetch-stop and lock signals, tags each response with its PC, and forwards it to the buffer.
- On a restart (branch/exception), flushes the buffer, discards stale in-flight responses and resumes at the new PC.

Parameters:
- P_OUTSTANDING, 4, maximum fetch requests in flight (1..7); also the PC tag FIFO depth.
- P_RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  asynchronous active-low reset
- iSTART  in  1  leave IDLE and begin fetching
- iFREE_RESTART  in  1  restart request (single-cycle level)
- iRESTART_PC  in  32  new fetch PC, valid with iFREE_RESTART
- oFETCH_REQ  out  1  fetch request valid
- oFETCH_ADDR  out  32  fetch address (word aligned)
- iFETCH_BUSY  in  1  memory cannot accept; request accepted when oFETCH_REQ && !iFETCH_BUSY
- iFETCH_VALID  in  1  in-order response valid
- iFETCH_INST  in  32  response instruction
- oBUFFER_INST_VALID  out  1  write strobe to loop buffer
- oBUFFER_INST  out  32  instruction to buffer
- oBUFFER_PC  out  32  PC of instruction to buffer
- oBUFFER_FLUSH  out  1  buffer remove strobe
- iBUFFER_FETCH_STOP  in  1  buffer near-full threshold
- iBUFFER_LOCK  in  1  buffer full
- oERROR  out  1  sticky protocol error

Behaviour:
- Reset (async, inRESET=0):
  - state=IDLE, pc=P_RESET_PC, outstanding=0, discard=0, tag FIFO empty, oERROR=0.
  - All strobes are low. oFETCH_ADDR=P_RESET_PC.
- States:
  - IDLE: no requests. Goes to RUN on iSTART=1.
  - RUN: normal fetching.
  - DRAIN: requests blocked until discard reaches 0, then returns to RUN.
  - There is no exit to IDLE except reset.
- Request gating:
  - oFETCH_REQ = (state==RUN) && !iBUFFER_FETCH_STOP && !iFREE_RESTART && (outstanding < P_OUTSTANDING).
  - oFETCH_ADDR = pc, combinational from the register.
- Request acceptance:
  - On accept: tag FIFO pushes pc, pc <= pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), outstanding++.
  - Accept and response in the same cycle leave outstanding unchanged.
- Response forwarding (zero latency, combinational):
  - Each iFETCH_VALID pops the tag FIFO if it is non-empty, and decrements outstanding.
  - Forward when discard==0 && !iFREE_RESTART: oBUFFER_INST_VALID=1, oBUFFER_INST=iFETCH_INST, oBUFFER_PC=tag FIFO head.
  - Otherwise the response is dropped; discard decrements if nonzero.
- Restart (iFREE_RESTART=1, state RUN or DRAIN):
  - oBUFFER_FLUSH=1 in the same cycle (combinational). No request is issued that cycle.
  - pc <= iRESTART_PC & ~32'h3.
  - Tag FIFO cleared.
  - discard <= outstanding - iFETCH_VALID.
  - outstanding <= discard value.
  - Next state = DRAIN if that value is nonzero, else RUN.
  - A restart in IDLE only loads pc.
  - A restart during DRAIN recomputes discard the same way; no double counting.
- Overrun safety: the buffer's fetch-stop threshold leaves at least P_OUTSTANDING free entries, so forwarded writes never need back-pressure.
- oERROR set (sticky until reset) on either of:
  - iFETCH_VALID with outstanding==0;
  - oBUFFER_INST_VALID=1 while iBUFFER_LOCK=1.
- iBUFFER_FETCH_STOP rising blocks new requests the same cycle. Responses already in flight are still accepted and forwarded.

Test Plan:
1. Reset, iSTART, iFETCH_BUSY=0, memory answering 2 cycles after accept, 8 requests -> oFETCH_ADDR sequence 0x0,0x4,...,0x1C. Each forwarded oBUFFER_PC matches its request. outstanding never exceeds 4.
2. Memory stalls responses, P_OUTSTANDING=4 -> exactly 4 accepts, then oFETCH_REQ=0. Resumes one request per returned response.
3. 3 requests outstanding, iFREE_RESTART with iRESTART_PC=0x1000 -> oBUFFER_FLUSH=1 that cycle, state DRAIN. Next 3 responses dropped (oBUFFER_INST_VALID=0). Then the first request is at 0x1000 and its response is forwarded with oBUFFER_PC=0x1000.
4. Restart in the same cycle as a response and a would-be accept -> no accept, that response dropped, discard=outstanding-1. A second restart during DRAIN to 0x2000 -> fetching resumes at 0x2000 only.
5. iBUFFER_FETCH_STOP held high for 10 cycles with 2 outstanding -> no requests issued, both responses forwarded. Requests resume the cycle it drops.
6. pc=0xFFFF_FFF8, two accepts -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0. A spurious iFETCH_VALID with outstanding=0 sets oERROR, which stays 1 until inRESET.

Source files
------------

// File: rtl/fetch_flow_controller.sv
// Instruction fetch sequencer: issues in-order fetches, caps requests in flight, tags
// responses with their PC for the loop buffer and discards stale responses after a restart.
module fetch_flow_controller #(
  parameter int unsigned P_OUTSTANDING = 4,
  parameter logic [31:0] P_RESET_PC    = 32'h0000_0000
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iSTART,
  input  logic        iFREE_RESTART,
  input  logic [31:0] iRESTART_PC,
  output logic        oFETCH_REQ,
  output logic [31:0] oFETCH_ADDR,
  input  logic        iFETCH_BUSY,
  input  logic        iFETCH_VALID,
  input  logic [31:0] iFETCH_INST,
  output logic        oBUFFER_INST_VALID,
  output logic [31:0] oBUFFER_INST,
  output logic [31:0] oBUFFER_PC,
  output logic        oBUFFER_FLUSH,
  input  logic        iBUFFER_FETCH_STOP,
  input  logic        iBUFFER_LOCK,
  output logic        oERROR
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} stateT;

  localparam int unsigned      PtrW    = (P_OUTSTANDING > 1) ? $clog2(P_OUTSTANDING) : 1;
  localparam logic [2:0]       MaxOut  = 3'(P_OUTSTANDING);
  localparam logic [PtrW-1:0]  LastPtr = PtrW'(P_OUTSTANDING - 1);

  stateT           state;
  logic [31:0]     pc;
  logic [2:0]      outstanding;
  logic [2:0]      discard;
  logic [2:0]      tagCount;
  logic [PtrW-1:0] rdPtr;
  logic [PtrW-1:0] wrPtr;
  logic [31:0]     tagMem [P_OUTSTANDING];
  logic            errorReg;

  logic       fetchReq;
  logic       accept;
  logic       forward;
  logic       respTaken;
  logic       push;
  logic       pop;
  logic       flush;
  logic [2:0] drainCount;
  logic [2:0] discardNext;

  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fetchReq    = (state == StRun) && !iBUFFER_FETCH_STOP && !iFREE_RESTART &&
                  (outstanding < MaxOut);
    accept      = fetchReq && !iFETCH_BUSY;
    forward     = iFETCH_VALID && (discard == 3'd0) && !iFREE_RESTART;
    respTaken   = iFETCH_VALID && (outstanding != 3'd0);
    push        = accept && (tagCount < MaxOut);
    pop         = iFETCH_VALID && (tagCount != 3'd0);
    flush       = iFREE_RESTART && (state != StIdle);
    // Requests still in flight after this cycle's response are all stale on a restart.
    drainCount  = outstanding - {2'b00, respTaken};
    discardNext = discard;
    if (iFETCH_VALID && !forward && (discard != 3'd0)) discardNext = discard - 3'd1;
  end

  always_ff @(posedge iCLOCK) begin
    if (push) tagMem[wrPtr] <= pc;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state       <= StIdle;
      pc          <= P_RESET_PC;
      outstanding <= 3'd0;
      discard     <= 3'd0;
      tagCount    <= 3'd0;
      rdPtr       <= '0;
      wrPtr       <= '0;
      errorReg    <= 1'b0;
    end else begin
      if (iFREE_RESTART) begin
        pc <= iRESTART_PC & ~32'h3;
      end else if (accept) begin
        pc <= pc + 32'd4;
      end

      if (flush) begin
        outstanding <= drainCount;
        discard     <= drainCount;
        tagCount    <= 3'd0;
        rdPtr       <= '0;
        wrPtr       <= '0;
      end else begin
        discard <= discardNext;
        unique case ({accept, respTaken})
          2'b10:   outstanding <= outstanding + 3'd1;
          2'b01:   outstanding <= outstanding - 3'd1;
          default: outstanding <= outstanding;
        endcase
        if (push) wrPtr <= nextPtr(wrPtr);
        if (pop)  rdPtr <= nextPtr(rdPtr);
        unique case ({push, pop})
          2'b10:   tagCount <= tagCount + 3'd1;
          2'b01:   tagCount <= tagCount - 3'd1;
          default: tagCount <= tagCount;
        endcase
      end

      unique case (state)
        StIdle:  if (iSTART) state <= StRun;
        StRun:   if (flush) state <= (drainCount != 3'd0) ? StDrain : StRun;
        StDrain: begin
          if (flush) state <= (drainCount != 3'd0) ? StDrain : StRun;
          else if (discardNext == 3'd0) state <= StRun;
        end
        default: state <= StIdle;
      endcase

      if ((iFETCH_VALID && (outstanding == 3'd0)) || (forward && iBUFFER_LOCK)) begin
        errorReg <= 1'b1;
      end
    end
  end

  assign oFETCH_REQ         = fetchReq;
  assign oFETCH_ADDR        = pc;
  assign oBUFFER_INST_VALID = forward;
  assign oBUFFER_INST       = iFETCH_INST;
  assign oBUFFER_PC         = tagMem[rdPtr];
  assign oBUFFER_FLUSH      = flush;
  assign oERROR             = errorReg;

endmodule
